// File: rtl/instr_mem_pkg.sv
// Shared types and width helpers for the instruction-memory bank front-end.
package instr_mem_pkg;

  localparam int unsigned BANK_LAT_MIN   = 1;
  localparam int unsigned BANK_LAT_MAX   = 2;
  localparam int unsigned BANK_IDX_MAX_W = 8;

  typedef struct packed {
    logic                      valid;
    logic                      is_rom;
    logic                      hit;
    logic [BANK_IDX_MAX_W-1:0] bank_idx;
    logic                      is_write;
    logic                      err;
  } tag_t;

  function automatic int unsigned bank_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned bank_addr_w(input int unsigned size);
    return $clog2(size);
  endfunction

  // Out-of-range latencies are pulled to the nearest legal value.
  function automatic int unsigned lat_legal(input int unsigned lat);
    return (lat < BANK_LAT_MIN) ? BANK_LAT_MIN :
           (lat > BANK_LAT_MAX) ? BANK_LAT_MAX : lat;
  endfunction

endpackage

// File: rtl/instr_mem_tag_pipe.sv
// Fixed-depth shift register of response tags; every stage advances each cycle.
module instr_mem_tag_pipe
  import instr_mem_pkg::*;
#(
  parameter int unsigned STAGES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  tag_t                    tag_i,
  output tag_t [STAGES-1:0]       stages_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages_o <= '0;
    end else begin
      stages_o[0] <= tag_i;
      for (int i = 1; i < STAGES; i++) stages_o[i] <= stages_o[i-1];
    end
  end

endmodule

// File: rtl/instr_mem_bank_wrap.sv
// Instruction-memory front-end: decodes to NUM_BANKS RAM banks or boot ROM, returns in-order responses.
// Optional last-word read buffer enabled by INSTR_MEM_LAST_WORD_BUF_EN.
module instr_mem_bank_wrap
  import instr_mem_pkg::*;
#(
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned BANK_SIZE      = 8192,
  parameter int unsigned BANK_LAT       = 1,
  parameter int unsigned ROM_ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = $clog2(NUM_BANKS*BANK_SIZE) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_i,
  output logic                              gnt_o,
  input  logic [ADDR_WIDTH-1:0]             addr_i,
  input  logic                              we_i,
  input  logic [DATA_WIDTH/8-1:0]           be_i,
  input  logic [DATA_WIDTH-1:0]             wdata_i,
  output logic                              rvalid_o,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic                              err_o,
  output logic [NUM_BANKS-1:0]              bank_en_o,
  output logic [$clog2(BANK_SIZE)-1:0]      bank_addr_o,
  output logic                              bank_we_o,
  output logic [DATA_WIDTH/8-1:0]           bank_be_o,
  output logic [DATA_WIDTH-1:0]             bank_wdata_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]   bank_rdata_i,
  output logic                              rom_en_o,
  output logic [ROM_ADDR_WIDTH-1:0]         rom_addr_o,
  input  logic [DATA_WIDTH-1:0]             rom_rdata_i
);

  localparam int unsigned BAW = bank_addr_w(BANK_SIZE);
  localparam int unsigned BIW = bank_idx_w(NUM_BANKS);
  localparam int unsigned LAT = lat_legal(BANK_LAT);
  localparam int unsigned WAW = ADDR_WIDTH - 2;

  logic                  is_rom, err_req, hit;
  logic [BIW-1:0]        bidx;
  logic [WAW-1:0]        waddr;
  logic [DATA_WIDTH-1:0] rd_word, hit_data;
  tag_t                  tag_in, last;
  tag_t [LAT-1:0]        stages;

  assign is_rom  = addr_i[ADDR_WIDTH-1];
  assign err_req = is_rom & we_i;
  assign waddr   = addr_i[ADDR_WIDTH-1:2];

  if (NUM_BANKS > 1) begin : g_bidx
    assign bidx = addr_i[BAW +: BIW];
  end else begin : g_bidx1
    assign bidx = '0;
  end

  assign gnt_o        = req_i;
  assign bank_addr_o  = addr_i[BAW-1:0];
  assign bank_we_o    = we_i;
  assign bank_be_o    = be_i;
  assign bank_wdata_o = wdata_i;
  assign rom_addr_o   = addr_i[ROM_ADDR_WIDTH+1:2];

  always_comb begin
    bank_en_o = '0;
    rom_en_o  = 1'b0;
    if (req_i && !err_req && !hit) begin
      if (is_rom) rom_en_o = 1'b1;
      else        bank_en_o[bidx] = 1'b1;
    end
  end

  always_comb begin
    tag_in          = '0;
    tag_in.valid    = req_i;
    tag_in.is_rom   = is_rom;
    tag_in.hit      = hit;
    tag_in.bank_idx = BANK_IDX_MAX_W'(bidx);
    tag_in.is_write = we_i;
    tag_in.err      = err_req;
  end

  instr_mem_tag_pipe #(.STAGES(LAT)) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .tag_i    (tag_in),
    .stages_o (stages)
  );

  assign last     = stages[LAT-1];
  assign rvalid_o = last.valid;
  assign err_o    = last.err;

  // Bank data is sampled from the tag's own bank index, never the current request.
  always_comb begin
    rd_word = rom_rdata_i;
    if (!last.is_rom) begin
      rd_word = '0;
      for (int k = 0; k < NUM_BANKS; k++)
        if (last.bank_idx == BANK_IDX_MAX_W'(k)) rd_word = bank_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    rdata_o = '0;
    if (last.valid && !last.is_write && !last.err) rdata_o = last.hit ? hit_data : rd_word;
  end

`ifdef INSTR_MEM_LAST_WORD_BUF_EN
  logic                  buf_vld, rd_busy, wr_inv, fill;
  logic [WAW-1:0]        buf_addr;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [LAT-1:0][WAW-1:0] ap;
  logic [LAT-1:0]        stale;

  always_comb begin
    rd_busy = 1'b0;
    for (int i = 0; i < LAT; i++)
      if (stages[i].valid && !stages[i].is_write && !stages[i].err) rd_busy = 1'b1;
  end

  assign hit    = req_i & ~we_i & buf_vld & (buf_addr == waddr) & ~rd_busy;
  assign wr_inv = req_i & we_i & (buf_addr == waddr);
  // A read overtaken by a write to its own word must not refill the buffer with stale data.
  assign fill   = last.valid & ~last.is_write & ~last.err & ~last.hit & ~stale[LAT-1] &
                  ~(req_i & we_i & (ap[LAT-1] == waddr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ap    <= '0;
      stale <= '0;
    end else begin
      ap[0]    <= waddr;
      stale[0] <= 1'b0;
      for (int i = 1; i < LAT; i++) begin
        ap[i]    <= ap[i-1];
        stale[i] <= stale[i-1] | (req_i & we_i & (ap[i-1] == waddr));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld  <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (wr_inv) begin
      buf_vld  <= 1'b0;
    end else if (fill) begin
      buf_vld  <= 1'b1;
      buf_addr <= ap[LAT-1];
      buf_data <= rd_word;
    end
  end

  assign hit_data = buf_data;
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

endmodule

// File: tb/tb_instr_mem_bank_wrap.sv
// Bench: BANK_LAT=1 and BANK_LAT=2 instances share stimulus; per-instance response scoreboards.
module tb_instr_mem_bank_wrap;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [3:0] be = 4'hF;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] bd [NB];
  logic [DW-1:0] rom_d;
  logic [NB*DW-1:0] bank_flat;

  logic gnt [2];
  logic rvalid [2];
  logic err [2];
  logic [DW-1:0] rdata [2];
  logic [NB-1:0] bank_en [2];
  logic [12:0] bank_addr [2];
  logic bank_we [2];
  logic [3:0] bank_be [2];
  logic [DW-1:0] bank_wdata [2];
  logic rom_en [2];
  logic [7:0] rom_addr [2];

  assign bank_flat = {bd[3], bd[2], bd[1], bd[0]};

  always #5 clk = ~clk;

  instr_mem_bank_wrap #(.BANK_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt[0]), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .bank_en_o(bank_en[0]), .bank_addr_o(bank_addr[0]), .bank_we_o(bank_we[0]),
    .bank_be_o(bank_be[0]), .bank_wdata_o(bank_wdata[0]), .bank_rdata_i(bank_flat),
    .rom_en_o(rom_en[0]), .rom_addr_o(rom_addr[0]), .rom_rdata_i(rom_d)
  );

  instr_mem_bank_wrap #(.BANK_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt[1]), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .bank_en_o(bank_en[1]), .bank_addr_o(bank_addr[1]), .bank_we_o(bank_we[1]),
    .bank_be_o(bank_be[1]), .bank_wdata_o(bank_wdata[1]), .bank_rdata_i(bank_flat),
    .rom_en_o(rom_en[1]), .rom_addr_o(rom_addr[1]), .rom_rdata_i(rom_d)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            due;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [NB-1:0] en;
    logic          rom_en;
    logic [7:0]    rom_addr;
    logic [DW-1:0] rdata;
    logic          err;
  } vec_t;

  exp_t q [2][$];
  vec_t vecs [14];
  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic issue(input vec_t v);
    exp_t e;
    req = 1'b1; addr = v.addr; we = v.we; wdata = v.wdata;
    for (int d = 0; d < 2; d++) begin
      e.data = v.rdata; e.err = v.err; e.due = cyc + d + 1;
      q[d].push_back(e);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("gnt[%0d]", d), 32'(gnt[d]), 32'd1);
      chk($sformatf("bank_en[%0d] a=%h", d, v.addr), 32'(bank_en[d]), 32'(v.en));
      chk($sformatf("rom_en[%0d] a=%h", d, v.addr), 32'(rom_en[d]), 32'(v.rom_en));
      chk($sformatf("bank_addr[%0d]", d), 32'(bank_addr[d]), 32'(v.addr[12:0]));
      chk($sformatf("bank_we[%0d]", d), 32'(bank_we[d]), 32'(v.we));
      if (v.rom_en) chk($sformatf("rom_addr[%0d]", d), 32'(rom_addr[d]), 32'(v.rom_addr));
    end
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every response must match the oldest expectation at its exact due cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      while (q[d].size() > 0 && q[d][0].due < cyc) begin
        n_run++; n_fail++;
        $display("FAIL missing_resp[%0d]: no rvalid, expected at cycle %0d", d, q[d][0].due);
        void'(q[d].pop_front());
      end
      if (rvalid[d]) begin
        if (q[d].size() == 0) begin
          n_run++; n_fail++;
          $display("FAIL spurious_resp[%0d]: rvalid=1 rdata=%h, expected no response (cycle %0d)", d, rdata[d], cyc);
        end else begin
          exp_t e;
          e = q[d].pop_front();
          chk($sformatf("rdata[%0d]", d), rdata[d], e.data);
          chk($sformatf("err[%0d]", d), 32'(err[d]), 32'(e.err));
          chk($sformatf("latency[%0d]", d), 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    bd[0] = 32'hDEADBEEF; bd[1] = 32'h11111111; bd[2] = 32'h22222222; bd[3] = 32'h33333333;
    rom_d = 32'hC0DE5A5A;
    vecs[0]  = '{16'h0004, 1'b0, 32'h0,        4'b0001, 1'b0, 8'h00, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{16'h6000, 1'b0, 32'h0,        4'b1000, 1'b0, 8'h00, 32'h33333333, 1'b0};
    vecs[2]  = '{16'h2000, 1'b0, 32'h0,        4'b0010, 1'b0, 8'h00, 32'h11111111, 1'b0};
    vecs[3]  = '{16'h8014, 1'b0, 32'h0,        4'b0000, 1'b1, 8'h05, 32'hC0DE5A5A, 1'b0};
    vecs[4]  = '{16'h8018, 1'b1, 32'h12345678, 4'b0000, 1'b0, 8'h06, 32'h0,        1'b1};
    vecs[5]  = '{16'h4000, 1'b1, 32'hA5A5A5A5, 4'b0100, 1'b0, 8'h00, 32'h0,        1'b0};
    vecs[6]  = '{16'h4010, 1'b0, 32'h0,        4'b0100, 1'b0, 8'h04, 32'h22222222, 1'b0};
    vecs[7]  = '{16'h7FFC, 1'b0, 32'h0,        4'b1000, 1'b0, 8'hFF, 32'h33333333, 1'b0};
    vecs[8]  = '{16'hFFFC, 1'b0, 32'h0,        4'b0000, 1'b1, 8'hFF, 32'hC0DE5A5A, 1'b0};
    vecs[9]  = '{16'h1FFC, 1'b0, 32'h0,        4'b0001, 1'b0, 8'hFF, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{16'h6004, 1'b0, 32'h0,        4'b1000, 1'b0, 8'h01, 32'h33333333, 1'b0};
    vecs[11] = '{16'h0008, 1'b0, 32'h0,        4'b0001, 1'b0, 8'h02, 32'hDEADBEEF, 1'b0};
    vecs[12] = '{16'h2004, 1'b0, 32'h0,        4'b0010, 1'b0, 8'h01, 32'h11111111, 1'b0};
    vecs[13] = '{16'h6008, 1'b0, 32'h0,        4'b1000, 1'b0, 8'h02, 32'h33333333, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_rvalid[%0d]", d), 32'(rvalid[d]), 32'd0);
      chk($sformatf("rst_err[%0d]", d), 32'(err[d]), 32'd0);
      chk($sformatf("rst_rdata[%0d]", d), rdata[d], 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle: no enables without a request
    addr = 16'h8014;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("idle_bank_en[%0d]", d), 32'(bank_en[d]), 32'd0);
      chk($sformatf("idle_rom_en[%0d]", d), 32'(rom_en[d]), 32'd0);
    end
    @(posedge clk); #1;

    // Back-to-back table
    for (int i = 0; i < 14; i++) issue(vecs[i]);
    idle(4);

    // Reset with two reads in flight
    issue(vecs[0]);
    issue(vecs[2]);
    rst_n = 1'b0;
    q[0].delete(); q[1].delete();
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("midrst_rvalid[%0d]", d), 32'(rvalid[d]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk($sformatf("postrst_rvalid[%0d]", d), 32'(rvalid[d]), 32'd0);
    end
    idle(1);

`ifdef INSTR_MEM_LAST_WORD_BUF_EN
    v = '{16'h0010, 1'b0, 32'h0, 4'b0001, 1'b0, 8'h04, 32'hDEADBEEF, 1'b0};
    issue(v);
    idle(3);
    bd[0] = 32'hCAFEF00D;
    v = '{16'h0010, 1'b0, 32'h0, 4'b0000, 1'b0, 8'h04, 32'hDEADBEEF, 1'b0};
    issue(v);
    idle(3);
    v = '{16'h0010, 1'b1, 32'hCAFEF00D, 4'b0001, 1'b0, 8'h04, 32'h0, 1'b0};
    issue(v);
    idle(3);
    v = '{16'h0010, 1'b0, 32'h0, 4'b0001, 1'b0, 8'h04, 32'hCAFEF00D, 1'b0};
    issue(v);
    idle(3);
`else
    v = '{16'h0010, 1'b0, 32'h0, 4'b0001, 1'b0, 8'h04, 32'hDEADBEEF, 1'b0};
    issue(v);
    issue(v);
    idle(3);
`endif

    idle(4);
    for (int d = 0; d < 2; d++) chk($sformatf("drained[%0d]", d), 32'(q[d].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
